fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
Single-clock controller that sequences the `memory` dual-port storage array as a synchronous FIFO.
- Owns the read/write pointers and drives `waddr`, `raddr`, `wclk_en`, `rclk_en`, `wfull` and `rempty` into the array.
- Exposes valid/ready handshakes to the producer (AHB-side write path) and the consumer (APB-side read path).
- Provides occupancy count, almost-full/almost-empty watermarks and a synchronous flush.
- The array's `wclk` and `rclk` both connect to `hclk`.

Parameters:
- ASIZE, 5, address width; DEPTH = 2**ASIZE = 32 entries.
- AF_THRESH, 30, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- hclk  input  1  single clock for controller and array.
- hresetn  input  1  asynchronous active-low reset.
- wr_valid  input  1  producer has a word to push.
- wr_ready  output  1  FIFO can accept a push (= !full).
- rd_valid  output  1  head word present (= !empty).
- rd_ready  input  1  consumer takes the head word.
- flush  input  1  synchronous clear of all contents.
- mem_wclk_en  output  1  to array `wclk_en`; high on an accepted push.
- mem_waddr  output  ASIZE  to array `waddr`.
- mem_raddr  output  ASIZE  to array `raddr`.
- mem_rclk_en  output  1  to array `rclk_en`.
- mem_wfull  output  1  to array `wfull`.
- mem_rempty  output  1  to array `rempty`.
- count  output  ASIZE+1  occupancy, 0..DEPTH.
- almost_full  output  1  watermark.
- almost_empty  output  1  watermark.

Behaviour:
- Pointers:
  - wptr and rptr are each ASIZE+1 bits; the MSB is the wrap bit.
  - mem_waddr = wptr[ASIZE-1:0]; mem_raddr = rptr[ASIZE-1:0].
- Flags and count:
  - empty = (wptr == rptr).
  - full = (MSBs differ and low ASIZE bits equal).
  - count = wptr - rptr, modulo 2**(ASIZE+1).
  - All flags and count are decoded from registered pointers only; no combinational path from wr_valid/rd_ready to any flag.
- Push: push = wr_valid & wr_ready. mem_wclk_en = push. The array writes at the hclk edge; wptr increments at the same edge.
- Pop:
  - pop = rd_valid & rd_ready.
  - mem_rclk_en = !empty, so the array's combinational read presents the head word during the same cycle rd_valid is high (zero-latency read).
  - rptr increments at the edge on pop.
- Write-to-read latency: a word pushed into an empty FIFO at edge N is visible with rd_valid=1 in the cycle after edge N. There is no write-to-read bypass in the same cycle.
- Full with pop: wr_ready is low while full, even if pop occurs that cycle. The push is accepted the following cycle.
- Simultaneous push and pop when neither full nor empty: both pointers advance, count is unchanged.
- Wrap-around: pointers wrap naturally; after DEPTH pushes wptr low bits return to 0 and the wrap bit toggles.
- Flush (synchronous):
  - Sets wptr = rptr = 0 at the next edge.
  - Overrides push/pop in the same cycle; a coincident push is dropped (mem_wclk_en forced low).
- Reset (async, hresetn low): wptr = rptr = 0, count = 0, empty=1, full=0, wr_ready=1, rd_valid=0, almost_empty=1, almost_full=0, mem_wclk_en=0, mem_rclk_en=0. Reset mid-transfer discards contents.
- mem_wfull = full; mem_rempty = empty.

Optional Feature:
- Macro: FIFO_CTRL_ERR_FLAG_EN.
- When defined:
  - Adds outputs ovf_err and udf_err (1 bit each), sticky.
  - ovf_err is set at an edge where wr_valid & full.
  - udf_err is set at an edge where rd_ready & empty.
  - Both are cleared by flush or reset.
- When undefined: ports absent; such attempts are silently ignored, with no state change.

Decomposition:
- Package fifo_ctrl_pkg:
  - FIFO_ASIZE_DEF = 5.
  - FIFO_DEPTH_DEF = 32.
  - Default watermark constants.
  - Pointer type, width ASIZE+1.
- Sub-module fifo_ptr:
  - Inputs: inc, clr, hclk, hresetn.
  - Output: an ASIZE+1-bit pointer register.
  - Instantiated twice, once for the write pointer and once for the read pointer.

Test Plan:
1. Reset: hold hresetn=0 for 3 cycles, then release → count=0, rd_valid=0, wr_ready=1, almost_empty=1, mem_waddr=mem_raddr=0.
2. Push 0xA0..0xBF (32 words) without popping → after 32nd edge full=1, wr_ready=0, count=32, almost_full asserted from count=30. A 33rd wr_valid is not accepted and the array is not written.
3. Pop all 32 words with rd_ready=1 → data order 0xA0..0xBF, then rd_valid=0, count=0. An extra rd_ready leaves rptr unchanged (udf_err=1 if FIFO_CTRL_ERR_FLAG_EN).
4. With count=5, hold wr_valid=rd_ready=1 for 40 cycles → count stays 5, both pointers wrap past 31→0, read data equals the write stream delayed by 5 words.
5. At count=32, assert rd_ready and wr_valid together → cycle 1 pops only (count 31), cycle 2 push accepted (count 32).
6. At count=12, assert flush and wr_valid in the same cycle → next cycle count=0, rd_valid=0, mem_wclk_en was 0, pointers 0. The following push of 0x55 is read back as 0x55.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
//   Shared constants and types for the FIFO controller slice.
//   - FIFO_ASIZE_DEF / FIFO_DEPTH_DEF : default address width and entry count
//   - FIFO_AF_THRESH_DEF / FIFO_AE_THRESH_DEF : default watermark levels
//   - fifo_ptr_t : pointer type at the default width (ASIZE+1, MSB = wrap bit)
package fifo_ctrl_pkg;

  localparam int FIFO_ASIZE_DEF     = 5;
  localparam int FIFO_DEPTH_DEF     = 32;
  localparam int FIFO_AF_THRESH_DEF = 30;
  localparam int FIFO_AE_THRESH_DEF = 2;

  typedef logic [FIFO_ASIZE_DEF:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr
//   One FIFO pointer register: ASIZE address bits plus a wrap bit.
//   Ports:
//     hclk    in   clock
//     hresetn in   asynchronous active-low reset (pointer -> 0)
//     inc     in   advance pointer by one at the next edge
//     clr     in   synchronous clear, has priority over inc
//     ptr     out  registered pointer value, ASIZE+1 bits
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int ASIZE = FIFO_ASIZE_DEF
) (
  input  logic           hclk,
  input  logic           hresetn,
  input  logic           inc,
  input  logic           clr,
  output logic [ASIZE:0] ptr
);

  logic [ASIZE:0] ptr_reg;
  logic [ASIZE:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (clr) begin
      ptr_next = '0;
    end else if (inc) begin
      // Natural wrap through the extra MSB distinguishes full from empty.
      ptr_next = ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
//   Synchronous FIFO controller sequencing an external dual-port array whose
//   read is combinational (zero-latency head word while rd_valid is high).
//   Ports:
//     hclk, hresetn          clock, asynchronous active-low reset
//     wr_valid / wr_ready    producer push handshake (wr_ready = !full)
//     rd_valid / rd_ready    consumer pop handshake (rd_valid = !empty)
//     flush                  synchronous clear of both pointers
//     mem_wclk_en            array write enable, high on an accepted push
//     mem_waddr, mem_raddr   array write / read addresses
//     mem_rclk_en            array read enable (= !empty)
//     mem_wfull, mem_rempty  full / empty status to the array
//     count                  occupancy 0..DEPTH
//     almost_full/_empty     watermarks (count >= AF_THRESH / <= AE_THRESH)
//   Optional build macro FIFO_CTRL_ERR_FLAG_EN adds sticky ovf_err / udf_err
//   outputs; without it, pushes while full and pops while empty are ignored.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ASIZE     = FIFO_ASIZE_DEF,
  parameter int AF_THRESH = FIFO_AF_THRESH_DEF,
  parameter int AE_THRESH = FIFO_AE_THRESH_DEF
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             rd_valid,
  input  logic             rd_ready,
  input  logic             flush,
  output logic             mem_wclk_en,
  output logic [ASIZE-1:0] mem_waddr,
  output logic [ASIZE-1:0] mem_raddr,
  output logic             mem_rclk_en,
  output logic             mem_wfull,
  output logic             mem_rempty,
  output logic [ASIZE:0]   count,
  output logic             almost_full,
  output logic             almost_empty
`ifdef FIFO_CTRL_ERR_FLAG_EN
  ,
  output logic             ovf_err,
  output logic             udf_err
`endif
);

  localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'(AF_THRESH);
  localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AE_THRESH);

  logic [ASIZE:0] ptr_val [2];   // [0] = write pointer, [1] = read pointer
  logic [1:0]     ptr_inc;
  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  // Status is decoded purely from the registered pointers, so there is no
  // combinational path from the handshake inputs to any flag.
  assign wptr  = ptr_val[0];
  assign rptr  = ptr_val[1];
  assign empty = (wptr == rptr);
  assign full  = (wptr[ASIZE] != rptr[ASIZE]) &&
                 (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign count = wptr - rptr;

  assign wr_ready = !full;
  assign rd_valid = !empty;

  // A push coincident with flush is dropped so the array is not written.
  assign push = wr_valid && wr_ready && !flush;
  assign pop  = rd_valid && rd_ready;

  assign ptr_inc = {pop, push};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      fifo_ptr #(
        .ASIZE (ASIZE)
      ) u_ptr (
        .hclk    (hclk),
        .hresetn (hresetn),
        .inc     (ptr_inc[gi]),
        .clr     (flush),
        .ptr     (ptr_val[gi])
      );
    end
  endgenerate

  assign mem_wclk_en  = push;
  assign mem_waddr    = wptr[ASIZE-1:0];
  assign mem_raddr    = rptr[ASIZE-1:0];
  assign mem_rclk_en  = !empty;
  assign mem_wfull    = full;
  assign mem_rempty   = empty;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

`ifdef FIFO_CTRL_ERR_FLAG_EN
  logic ovf_err_reg;
  logic ovf_err_next;
  logic udf_err_reg;
  logic udf_err_next;

  always_comb begin
    ovf_err_next = ovf_err_reg;
    udf_err_next = udf_err_reg;
    if (flush) begin
      ovf_err_next = 1'b0;
      udf_err_next = 1'b0;
    end else begin
      if (wr_valid && full) ovf_err_next = 1'b1;
      if (rd_ready && empty) udf_err_next = 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ovf_err_reg <= 1'b0;
      udf_err_reg <= 1'b0;
    end else begin
      ovf_err_reg <= ovf_err_next;
      udf_err_reg <= udf_err_next;
    end
  end

  assign ovf_err = ovf_err_reg;
  assign udf_err = udf_err_reg;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl
//   Directed bench for fifo_ctrl. A queue-based FIFO model plus a behavioural
//   copy of the storage array give the expected outputs every cycle; literal
//   checks in the stimulus pin the model to hand-computed values.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int ASIZE = FIFO_ASIZE_DEF;
  localparam int DEPTH = FIFO_DEPTH_DEF;

  logic           hclk = 1'b0;
  logic           hresetn = 1'b0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic           rd_valid;
  logic           rd_ready = 1'b0;
  logic           flush = 1'b0;
  logic           mem_wclk_en;
  logic [ASIZE-1:0] mem_waddr;
  logic [ASIZE-1:0] mem_raddr;
  logic           mem_rclk_en;
  logic           mem_wfull;
  logic           mem_rempty;
  fifo_ptr_t      count;
  logic           almost_full;
  logic           almost_empty;
`ifdef FIFO_CTRL_ERR_FLAG_EN
  logic           ovf_err;
  logic           udf_err;
`endif

  logic [7:0] wdata = 8'h00;
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata;

  int tests = 0;
  int fails = 0;

  fifo_ctrl dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .flush        (flush),
    .mem_wclk_en  (mem_wclk_en),
    .mem_waddr    (mem_waddr),
    .mem_raddr    (mem_raddr),
    .mem_rclk_en  (mem_rclk_en),
    .mem_wfull    (mem_wfull),
    .mem_rempty   (mem_rempty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef FIFO_CTRL_ERR_FLAG_EN
    ,
    .ovf_err      (ovf_err),
    .udf_err      (udf_err)
`endif
  );

  always #5 hclk = ~hclk;

  // Behavioural storage array: written on the DUT's enable, read combinationally.
  always @(posedge hclk) begin
    if (mem_wclk_en) mem[mem_waddr] <= wdata;
  end
  assign rdata = mem[mem_raddr];

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  int  m_wtot = 0;   // pushes since last clear
  int  m_rtot = 0;   // pops since last clear
  int  m_size;
  bit  m_push;
  bit  m_pop;
  bit  m_ovf = 0;
  bit  m_udf = 0;

  assign m_size = m_wtot - m_rtot;
  assign m_push = wr_valid && (m_size < DEPTH) && !flush;
  assign m_pop  = rd_ready && (m_size > 0) && !flush;

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      q.delete();
      m_wtot <= 0;
      m_rtot <= 0;
      m_ovf  <= 0;
      m_udf  <= 0;
    end else if (flush) begin
      q.delete();
      m_wtot <= 0;
      m_rtot <= 0;
      m_ovf  <= 0;
      m_udf  <= 0;
    end else begin
      if (m_push) begin
        q.push_back(wdata);
        m_wtot <= m_wtot + 1;
      end
      if (m_pop) begin
        void'(q.pop_front());
        m_rtot <= m_rtot + 1;
      end
      if (wr_valid && m_size == DEPTH) m_ovf <= 1;
      if (rd_ready && m_size == 0) m_udf <= 1;
    end
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge hclk) begin
    check("count",        32'(count),        32'(m_size));
    check("wr_ready",     32'(wr_ready),     32'(m_size < DEPTH));
    check("rd_valid",     32'(rd_valid),     32'(m_size > 0));
    check("mem_wfull",    32'(mem_wfull),    32'(m_size == DEPTH));
    check("mem_rempty",   32'(mem_rempty),   32'(m_size == 0));
    check("mem_rclk_en",  32'(mem_rclk_en),  32'(m_size > 0));
    check("mem_wclk_en",  32'(mem_wclk_en),  32'(m_push));
    check("mem_waddr",    32'(mem_waddr),    32'(m_wtot % DEPTH));
    check("mem_raddr",    32'(mem_raddr),    32'(m_rtot % DEPTH));
    check("almost_full",  32'(almost_full),  32'(m_size >= FIFO_AF_THRESH_DEF));
    check("almost_empty", 32'(almost_empty), 32'(m_size <= FIFO_AE_THRESH_DEF));
    if (m_size > 0 && rd_valid) check("rdata", 32'(rdata), 32'(q[0]));
`ifdef FIFO_CTRL_ERR_FLAG_EN
    check("ovf_err", 32'(ovf_err), 32'(m_ovf));
    check("udf_err", 32'(udf_err), 32'(m_udf));
`endif
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // 1. reset held for 3 cycles
    repeat (3) tick();
    hresetn = 1'b1;
    tick();
    check("rst_count",    32'(count),        32'd0);
    check("rst_rd_valid", 32'(rd_valid),     32'd0);
    check("rst_wr_ready", 32'(wr_ready),     32'd1);
    check("rst_ae",       32'(almost_empty), 32'd1);
    check("rst_waddr",    32'(mem_waddr),    32'd0);
    check("rst_raddr",    32'(mem_raddr),    32'd0);

    // 2. fill with 0xA0..0xBF, then one rejected push
    wr_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wdata = 8'hA0 + 8'(i);
      if (i == 29) check("af_at_29", 32'(almost_full), 32'd0);
      if (i == 30) check("af_at_30", 32'(almost_full), 32'd1);
      tick();
    end
    check("full_count",    32'(count),    32'd32);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    check("full_af",       32'(almost_full), 32'd1);
    wdata = 8'hEE;
    check("push33_wen",    32'(mem_wclk_en), 32'd0);
    tick();
    wr_valid = 1'b0;
    check("push33_nowrite", 32'(mem[0]), 32'hA0);
    check("push33_count",   32'(count),  32'd32);

    // 3. drain all 32, then one extra pop attempt
    rd_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("drain_data", 32'(rdata), 32'(8'hA0 + 8'(i)));
      tick();
    end
    check("drain_rd_valid", 32'(rd_valid), 32'd0);
    check("drain_count",    32'(count),    32'd0);
    tick();
    rd_ready = 1'b0;
    check("extra_pop_raddr", 32'(mem_raddr), 32'd0);
    check("extra_pop_count", 32'(count),     32'd0);
`ifdef FIFO_CTRL_ERR_FLAG_EN
    check("udf_set", 32'(udf_err), 32'd1);
`endif

    // 4. count = 5, then 40 cycles of simultaneous push/pop
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 8'h10 + 8'(i);
      tick();
    end
    check("five_count", 32'(count), 32'd5);
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wdata = 8'h20 + 8'(i);
      check("stream_data", 32'(rdata),
            (i < 5) ? 32'(8'h10 + 8'(i)) : 32'(8'h20 + 8'(i - 5)));
      tick();
    end
    rd_ready = 1'b0;
    check("stream_count", 32'(count),     32'd5);
    check("stream_waddr", 32'(mem_waddr), 32'd13);  // 32+5+40 = 77 -> 13
    check("stream_raddr", 32'(mem_raddr), 32'd8);   // 32+40    = 72 -> 8

    // 5. fill to 32, then push+pop while full
    for (int i = 0; i < 27; i++) begin
      wdata = 8'h60 + 8'(i);
      tick();
    end
    check("refill_count", 32'(count), 32'd32);
    rd_ready = 1'b1;
    wdata = 8'h99;
    check("fullpop_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    check("fullpop_count", 32'(count), 32'd31);
    rd_ready = 1'b0;
    tick();
    wr_valid = 1'b0;
    check("fullpop_push_count", 32'(count), 32'd32);

    // 6. pop down to 12, then flush with a coincident push
    rd_ready = 1'b1;
    repeat (20) tick();
    rd_ready = 1'b0;
    check("pre_flush_count", 32'(count), 32'd12);
    flush = 1'b1;
    wr_valid = 1'b1;
    wdata = 8'h77;
    check("flush_wen", 32'(mem_wclk_en), 32'd0);
    tick();
    flush = 1'b0;
    wr_valid = 1'b0;
    check("flush_count",    32'(count),     32'd0);
    check("flush_rd_valid", 32'(rd_valid),  32'd0);
    check("flush_waddr",    32'(mem_waddr), 32'd0);
    check("flush_raddr",    32'(mem_raddr), 32'd0);
    wr_valid = 1'b1;
    wdata = 8'h55;
    tick();
    wr_valid = 1'b0;
    check("post_flush_valid", 32'(rd_valid), 32'd1);
    check("post_flush_data",  32'(rdata),    32'h55);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("post_flush_empty", 32'(rd_valid), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
